// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic ops and a multi-cycle shift-add multiplier
// behind a valid/ready handshake on both the operand and result sides.
module seq_alu #(
    parameter int WIDTH               = 8,
    parameter int MUL_STEPS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 cout,
    output logic                 ovf
);

    localparam int MUL_CYCLES = WIDTH / MUL_STEPS_PER_CYCLE;
    localparam int CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_cout;
    logic                 alu_ovf;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum;

    // Single-cycle ops; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        b_eff    = (op == 3'd1) ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == 3'd1)};
        case (op)
            3'd0, 3'd1: begin
                alu_res  = {{WIDTH{sum[WIDTH-1]}}, sum[WIDTH-1:0]};
                alu_cout = sum[WIDTH];
                alu_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2:    alu_res = {{WIDTH{1'b0}}, a | b};
            3'd3:    alu_res = {{WIDTH{1'b0}}, a ^ b};
            3'd4:    alu_res = {{WIDTH{1'b0}}, a & b};
            default: alu_res = '0;
        endcase
    end

    // Partial products for the multiplier bits retired this cycle.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEPS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        case (state)
            IDLE: if (in_valid) state_next = (op == 3'd5) ? MUL : DONE;
            MUL:  if (cnt == LAST_CNT) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The result register doubles as the multiplier accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op == 3'd5) begin
                            out    <= '0;
                            cout   <= 1'b0;
                            ovf    <= 1'b0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else begin
                            out  <= alu_res;
                            cout <= alu_cout;
                            ovf  <= alu_ovf;
                        end
                    end
                end
                MUL: begin
                    out    <= out + partial;
                    mcand  <= mcand << MUL_STEPS_PER_CYCLE;
                    mplier <= mplier >> MUL_STEPS_PER_CYCLE;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu against an arithmetic reference model
// (main instance WIDTH=4/steps 1, second instance WIDTH=8/steps 2).
module tb_seq_alu;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, cout, ovf;
    logic [3:0] a, b;
    logic [2:0] op;
    logic [7:0] out;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic [15:0] out8;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(4), .MUL_STEPS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .ovf(ovf)
    );

    seq_alu #(.WIDTH(8), .MUL_STEPS_PER_CYCLE(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {cout, ovf, out[15:0]} for a w-bit ALU, from plain integer arithmetic.
    function automatic logic [17:0] model(input int w, input int o, input int x, input int y);
        int m, h, sx, sy, r, lo, res;
        logic cc, vv;
        m  = 1 << w;
        h  = m >> 1;
        sx = (x >= h) ? x - m : x;
        sy = (y >= h) ? y - m : y;
        cc = 1'b0;
        vv = 1'b0;
        res = 0;
        case (o)
            0: begin
                lo  = (x + y) % m;
                cc  = (x + y >= m);
                r   = sx + sy;
                vv  = (r >= h) || (r < -h);
                res = (lo >= h) ? lo + (m - 1) * m : lo;
            end
            1: begin
                lo  = (x - y + m) % m;
                cc  = (x >= y);
                r   = sx - sy;
                vv  = (r >= h) || (r < -h);
                res = (lo >= h) ? lo + (m - 1) * m : lo;
            end
            2: res = x | y;
            3: res = x ^ y;
            4: res = x & y;
            5: res = x * y;
            default: res = 0;
        endcase
        return {cc, vv, res[15:0]};
    endfunction

    task automatic run_op(input int o, input int x, input int y, input int hold);
        logic [17:0] e;
        int lat;
        int exp_lat;
        e = model(4, o, x, y);
        exp_lat = (o == 5) ? 5 : 1;
        chk("in_ready_before", in_ready, 1);
        in_valid = 1'b1;
        a = 4'(x);
        b = 4'(y);
        op = 3'(o);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency op%0d", o), lat, exp_lat);
        chk($sformatf("out op%0d %0h,%0h", o, x, y), out, e[7:0]);
        chk($sformatf("cout op%0d %0h,%0h", o, x, y), cout, e[17]);
        chk($sformatf("ovf op%0d %0h,%0h", o, x, y), ovf, e[16]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold", {out_valid, in_ready, cout, ovf, out}, {2'b10, e[17:16], e[7:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release", {in_ready, out_valid}, 2'b10);
    endtask

    task automatic run_op8(input int o, input int x, input int y);
        logic [17:0] e;
        int lat;
        e = model(8, o, x, y);
        in_valid8 = 1'b1;
        a8 = 8'(x);
        b8 = 8'(y);
        op8 = 3'(o);
        out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("w8 latency op%0d", o), lat, (o == 5) ? 5 : 1);
        chk($sformatf("w8 result op%0d %0h,%0h", o, x, y), {cout8, ovf8, out8}, e);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("w8 release", in_ready8, 1);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {out_valid, cout, ovf, out}, 11'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", in_ready, 1);

        run_op(0, 7, 1, 0);
        run_op(1, 3, 5, 0);
        run_op(1, 5, 3, 0);
        run_op(5, 15, 15, 0);
        run_op(4, 12, 10, 10);
        run_op(6, 15, 15, 0);
        run_op(1, 0, 8, 1);

        // Reset pulse in the third MUL cycle must abort the product.
        in_valid = 1'b1; a = 4'd13; b = 4'd11; op = 3'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out", {out_valid, out}, 9'd0);
        chk("abort in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort no valid", seen, 0);
        run_op(3, 15, 5, 0);

        for (int i = 0; i < 150; i++) begin
            run_op($urandom_range(7, 0), $urandom_range(15, 0), $urandom_range(15, 0),
                   $urandom_range(3, 0));
        end

        run_op8(5, 255, 255);
        run_op8(0, 127, 1);
        for (int i = 0; i < 30; i++) begin
            run_op8($urandom_range(7, 0), $urandom_range(255, 0), $urandom_range(255, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
